// File: rtl/sram_rw_port_ctrl_pkg.sv
// Shared types and helpers for the RW0 SRAM port controller.
package sram_rw_port_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // A read may issue only if it still has a slot once this cycle's pop is counted.
  function automatic logic read_credit_ok(input logic [1:0] occ,
                                          input logic       inflight,
                                          input logic       pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/sram_resp_fifo2.sv
// Two-entry synchronous FIFO holding captured read data until the consumer takes it.
module sram_resp_fifo2 #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        occ_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem0_q, mem1_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q   <= {DATA_W{1'b0}};
      mem1_q   <= {DATA_W{1'b0}};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        if (wr_ptr_q) mem1_q <= data_i;
        else          mem0_q <= data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = rd_ptr_q ? mem1_q : mem0_q;

  sram_resp_fifo2_chk u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_i),
    .pop_i  (pop_i),
    .occ_i  (occ_q)
  );

endmodule

// File: rtl/sram_resp_fifo2_chk.sv
// Overflow checker for the 2-entry response FIFO.
module sram_resp_fifo2_chk (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       push_i,
  input logic       pop_i,
  input logic [1:0] occ_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (occ_i == 2'd2) && !pop_i));

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Valid/ready initiator for a single-port RW0 SRAM macro with optional
// post-reset sweep and a credit-controlled 2-entry read response buffer.
module sram_rw_port_ctrl
  import sram_rw_port_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 9,
  parameter int unsigned       DATA_W        = 64,
  parameter int unsigned       MASK_W        = 8,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_busy,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  req_t              req_s;
  logic [1:0]        occ_s;
  logic              pop_s, fire_s;

  // Reset is folded in so nothing is offered to either side while it is held.
  always_comb begin
    req_s      = '{write: req_write, addr: req_addr, wmask: req_wmask, wdata: req_wdata};
    pop_s      = resp_valid && resp_ready;
    req_ready  = reset && (state_q == ST_RUN) &&
                 (req_s.write || read_credit_ok(occ_s, inflight_q, pop_s));
    fire_s     = req_valid && req_ready;
    init_busy  = (state_q == ST_INIT);
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = {ADDR_W{1'b0}};
    RW0_wmask  = {MASK_W{1'b0}};
    RW0_wdata  = {DATA_W{1'b0}};
    if (!reset) begin
      RW0_en = 1'b0;
    end else if (state_q == ST_INIT) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = cnt_q;
      RW0_wmask = {MASK_W{1'b1}};
      RW0_wdata = INIT_VALUE;
    end else if (fire_s) begin
      RW0_en    = 1'b1;
      RW0_wmode = req_s.write;
      RW0_addr  = req_s.addr;
      RW0_wmask = req_s.wmask;
      RW0_wdata = req_s.wdata;
    end else begin
      RW0_en = 1'b0;
    end
  end

  // The sweep ends on the last address itself rather than on counter wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = fire_s && !req_s.write;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
        else                         state_d = ST_INIT;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Controller state; an in-flight read is simply dropped on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q      <= {ADDR_W{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  sram_resp_fifo2 #(.DATA_W(DATA_W)) u_resp_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (inflight_q),
    .pop_i  (pop_s),
    .data_i (RW0_rdata),
    .occ_o  (occ_s),
    .head_o (resp_rdata)
  );

  assign resp_valid = (occ_s != 2'd0);

endmodule
